fwrisc_operand_fetch: RTL and testbench

//  Operand-fetch stage between decode and execute. Accepts a source-register pair

---
 rtl/fwrisc_operand_fetch.sv | 110 +++++++++++
 tb/tb_fwrisc_operand_fetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_operand_fetch.sv
// Operand-fetch stage: issues regfile reads for a decoded rs1/rs2 pair, captures the
// operands one cycle later and keeps them coherent with write-back until execute takes them.
module fwrisc_operand_fetch #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              flush,
    output logic [ADDR_W-1:0] ra_raddr,
    output logic [ADDR_W-1:0] rb_raddr,
    input  logic [DATA_W-1:0] ra_rdata,
    input  logic [DATA_W-1:0] rb_rdata,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_rs1,
    output logic [ADDR_W-1:0] out_rs2,
    output logic [DATA_W-1:0] out_rs1_data,
    output logic [DATA_W-1:0] out_rs2_data
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FULL
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              hit1;
    logic              hit2;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [DATA_W-1:0] data1_q;
    logic [DATA_W-1:0] data2_q;
    logic [DATA_W-1:0] capture1;
    logic [DATA_W-1:0] capture2;

    // Gating with reset keeps in_ready low while the stage is held in reset.
    always_comb begin
        in_ready   = 1'b0;
        accept     = 1'b0;
        state_next = state;
        if (reset && !flush) begin
            in_ready = (state == IDLE) || ((state == FULL) && out_ready);
        end
        accept = in_valid && in_ready;
        case (state)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = FULL;
            FULL:    if (out_ready) state_next = accept ? READ : IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Write-back to x0 never matches, so an x0 operand stays zero.
    always_comb begin
        hit1     = FWD_EN && wb_wen && (wb_waddr != '0) && (wb_waddr == rs1_q);
        hit2     = FWD_EN && wb_wen && (wb_waddr != '0) && (wb_waddr == rs2_q);
        capture1 = hit1 ? wb_wdata : ra_rdata;
        capture2 = hit2 ? wb_wdata : rb_rdata;
        if (rs1_q == '0) capture1 = '0;
        if (rs2_q == '0) capture2 = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
            end
            if (state == READ) begin
                data1_q <= capture1;
                data2_q <= capture2;
            end else if (state == FULL) begin
                if (hit1) data1_q <= wb_wdata;
                if (hit2) data2_q <= wb_wdata;
            end
        end
    end

    // Read addresses bypass the register only in the cycle a request is taken.
    assign ra_raddr     = accept ? in_rs1 : rs1_q;
    assign rb_raddr     = accept ? in_rs2 : rs2_q;
    assign out_valid    = (state == FULL);
    assign out_rs1      = rs1_q;
    assign out_rs2      = rs2_q;
    assign out_rs1_data = data1_q;
    assign out_rs2_data = data2_q;

endmodule

// File: tb/tb_fwrisc_operand_fetch.sv
// Bench for fwrisc_operand_fetch: directed scenarios followed by random traffic, checked
// against a transaction-level model in which a held forwarded operand always equals the regfile.
module tb_fwrisc_operand_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_rs1 = '0;
    logic [5:0]  in_rs2 = '0;
    logic        flush = 1'b0;
    logic [5:0]  ra_raddr;
    logic [5:0]  rb_raddr;
    logic [31:0] ra_rdata;
    logic [31:0] rb_rdata;
    logic [5:0]  wb_waddr = '0;
    logic [31:0] wb_wdata = '0;
    logic        wb_wen = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_rs1;
    logic [5:0]  out_rs2;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;

    logic        nf_in_ready;
    logic [5:0]  nf_ra_raddr;
    logic [5:0]  nf_rb_raddr;
    logic        nf_out_valid;
    logic [5:0]  nf_out_rs1;
    logic [5:0]  nf_out_rs2;
    logic [31:0] nf_out_rs1_data;
    logic [31:0] nf_out_rs2_data;

    int vectorCount = 0;
    int miscompares = 0;

    bit         pending = 1'b0;
    int         issueCycle = 0;
    int         cycle = 0;
    logic [5:0] lastRs1 = '0;
    logic [5:0] lastRs2 = '0;

    always #5 clock = ~clock;

    fwrisc_operand_fetch #(.ADDR_W(6), .DATA_W(32), .FWD_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .flush(flush),
        .ra_raddr(ra_raddr), .rb_raddr(rb_raddr), .ra_rdata(ra_rdata), .rb_rdata(rb_rdata),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_wen(wb_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data)
    );

    fwrisc_operand_fetch #(.ADDR_W(6), .DATA_W(32), .FWD_EN(1'b0)) dut_nofwd (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(nf_in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .flush(flush),
        .ra_raddr(nf_ra_raddr), .rb_raddr(nf_rb_raddr), .ra_rdata(ra_rdata), .rb_rdata(rb_rdata),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_wen(wb_wen),
        .out_valid(nf_out_valid), .out_ready(out_ready), .out_rs1(nf_out_rs1), .out_rs2(nf_out_rs2),
        .out_rs1_data(nf_out_rs1_data), .out_rs2_data(nf_out_rs2_data)
    );

    // Regfile: address registered at the edge, array read from the registered address.
    logic [31:0] mem [64];
    logic [5:0]  raQ = '0;
    logic [5:0]  rbQ = '0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
    end

    always @(posedge clock) begin
        raQ <= ra_raddr;
        rbQ <= rb_raddr;
        if (wb_wen && wb_waddr != 6'd0) mem[wb_waddr] <= wb_wdata;
    end

    assign ra_rdata = mem[raQ];
    assign rb_rdata = mem[rbQ];

    function automatic logic [31:0] regValue(input logic [5:0] a);
        return (a == 6'd0) ? 32'd0 : mem[a];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive, check against the model, then advance the model across the edge.
    task automatic applyStimulus(input bit iv, input logic [5:0] r1, input logic [5:0] r2,
                                 input bit ordy, input bit fl, input bit wen,
                                 input logic [5:0] wa, input logic [31:0] wd);
        bit expValid;
        bit expReady;
        bit expAccept;
        @(negedge clock);
        in_valid  = iv;
        in_rs1    = r1;
        in_rs2    = r2;
        out_ready = ordy;
        flush     = fl;
        wb_wen    = wen;
        wb_waddr  = wa;
        wb_wdata  = wd;
        #1;
        expValid  = pending && (cycle >= issueCycle + 2);
        expReady  = !fl && (!pending || (expValid && ordy));
        expAccept = iv && expReady;
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expValid});
        checkOutput("ra_raddr", {26'd0, ra_raddr}, {26'd0, expAccept ? r1 : lastRs1});
        checkOutput("rb_raddr", {26'd0, rb_raddr}, {26'd0, expAccept ? r2 : lastRs2});
        if (expValid) begin
            checkOutput("out_rs1", {26'd0, out_rs1}, {26'd0, lastRs1});
            checkOutput("out_rs2", {26'd0, out_rs2}, {26'd0, lastRs2});
            checkOutput("rs1_data", out_rs1_data, regValue(lastRs1));
            checkOutput("rs2_data", out_rs2_data, regValue(lastRs2));
        end
        @(posedge clock);
        if (fl || (expValid && ordy)) pending = 1'b0;
        if (expAccept) begin
            pending    = 1'b1;
            issueCycle = cycle;
            lastRs1    = r1;
            lastRs2    = r2;
        end
        cycle++;
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(negedge clock);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rel_in_ready", {31'd0, in_ready}, 32'd1);

        applyStimulus(0, 0, 0, 0, 0, 1, 6'd3, 32'h11);
        applyStimulus(0, 0, 0, 0, 0, 1, 6'd4, 32'h22);

        applyStimulus(1, 6'd3, 6'd4, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        #1;
        checkOutput("basic_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("basic_rs1", out_rs1_data, 32'h11);
        checkOutput("basic_rs2", out_rs2_data, 32'h22);

        applyStimulus(1, 6'd3, 6'd4, 1, 0, 0, 0, 0);
        #1;
        checkOutput("b2b_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("b2b_raddr", {26'd0, ra_raddr}, 32'd3);
        applyStimulus(0, 0, 0, 0, 0, 1, 6'd3, 32'hAA);
        #1;
        checkOutput("fwd_read_rs1", out_rs1_data, 32'hAA);
        checkOutput("nofwd_read_rs1", nf_out_rs1_data, 32'h11);

        applyStimulus(0, 0, 0, 0, 0, 1, 6'd4, 32'h55);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("hold_rs2", out_rs2_data, 32'h55);
        checkOutput("hold_rs1", out_rs1_data, 32'hAA);

        applyStimulus(1, 6'd4, 6'd4, 1, 0, 0, 0, 0);
        #1;
        checkOutput("same_raddr", {26'd0, ra_raddr}, 32'd4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 6'd4, 32'h66);
        #1;
        checkOutput("same_rs1", out_rs1_data, 32'h66);
        checkOutput("same_rs2", out_rs2_data, 32'h66);

        applyStimulus(1, 6'd0, 6'd4, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 6'd0, 32'hFFFF_FFFF);
        applyStimulus(0, 0, 0, 0, 0, 1, 6'd0, 32'hFFFF_FFFF);
        #1;
        checkOutput("x0_rs1", out_rs1_data, 32'd0);

        applyStimulus(1, 6'd3, 6'd4, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        #1;
        checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        #1;
        checkOutput("flush_valid2", {31'd0, out_valid}, 32'd0);

        applyStimulus(1, 6'd6, 6'd7, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("areset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("areset_raddr", {26'd0, ra_raddr}, 32'd0);
        checkOutput("areset_data", out_rs1_data, 32'd0);
        pending = 1'b0;
        lastRs1 = '0;
        lastRs2 = '0;
        in_valid = 1'b0;
        flush = 1'b0;
        wb_wen = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("rerel_in_ready", {31'd0, in_ready}, 32'd1);

        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 1) == 1,
                          6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

endmodule
